selector_arbiter: RTL and testbench
===================================

SELECTOR_ARBITER -- requirements
Module: selector_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 8, maximum consecutive grant cycles before preemption (legal 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_0..req_3  input  1 each  requester n wants the shared 4:1 selector path.
REQ-005 sel_1, sel_0  output  1 each  registered select code for the 4:1 selector; {sel_1,sel_0}=owner index.
REQ-006 en  output  1  registered active-low selector enable; 0 = path enabled, 1 = path disabled.
REQ-007 gnt_0..gnt_3  output  1 each  registered one-hot grant; all-zero when no owner.
REQ-008 busy  output  1  registered; 1 whenever state is not IDLE.

Function
REQ-009 The FSM SHALL have three states: IDLE, GRANT, GAP.
REQ-010 IDLE: en=1, gnt=0000; if any req high at an edge, the next state SHALL be GRANT to the round-robin winner, else IDLE.
REQ-011 Round-robin: a 2-bit pointer ptr holds the last owner; the search order SHALL be ptr+1, ptr+2, ptr+3, ptr (mod 4), first high req wins.
REQ-012 Entering GRANT SHALL register sel=winner, gnt one-hot for the winner, en=0, hold counter=1, ptr=winner, all in the same edge (one-cycle latency from req to grant).
REQ-013 GRANT, owner req low at an edge: next state GAP.
REQ-014 GRANT, owner req high and counter<HOLD_MAX: stay, counter+1.
REQ-015 GRANT, counter=HOLD_MAX and another req high: next state GAP (preemption).
REQ-016 GRANT, counter=HOLD_MAX and no other req high: stay; counter SHALL saturate at HOLD_MAX, no preemption.
REQ-017 GAP: exactly one cycle, en=1, gnt=0000, sel holds its previous value; at the next edge, arbitration per REQ-011 -> GRANT, else IDLE.
REQ-018 The previous owner SHALL be eligible from GAP only if no other req is high (lowest priority).
REQ-019 en=0 SHALL occur only in GRANT; gnt SHALL never have more than one bit set; the enable sense SHALL never change without a GAP or IDLE cycle between owners.
REQ-020 Requests are level-sensitive; req pulses that fall between edges are not recorded.
REQ-021 HOLD_MAX=1: every grant lasts one cycle when contention exists.

Reset
REQ-022 While rst=1, outputs SHALL immediately be: en=1, sel_1=0, sel_0=0, gnt=0000, busy=0; state=IDLE, ptr=3, counter=0.
REQ-023 Reset asserted mid-grant SHALL abort the grant with no GAP; after release, priority restarts at req_0.

Structure
REQ-024 The shared package selector_arb_pkg SHALL hold the state encodings (IDLE=2'd0, GRANT=2'd1, GAP=2'd2) and the counter width CNT_W=8.
REQ-025 Round-robin selection SHALL be a combinational sub-module rr_pick4 (inputs: 4 req bits, ptr; outputs: valid, 2-bit winner).
REQ-026 All outputs SHALL be driven directly from flops; total RTL 120-400 lines.

Verification (HOLD_MAX=4 unless noted)
REQ-027 Assert rst for 2 cycles with all req=1 -> en=1, sel=00, gnt=0000, busy=0 throughout, no grant before release.
REQ-028 Only req_2 high from IDLE -> one edge later gnt=0100, sel=10, en=0; held 20 cycles without GAP.
REQ-029 req_0 and req_1 held high -> gnt_0 for 4 cycles, 1 GAP cycle (en=1), gnt_1 for 4, GAP, gnt_0 ...
REQ-030 All req high -> owner order 0,1,2,3,0 with one GAP between each 4-cycle grant.
REQ-031 req_1 owner drops after 2 grant cycles while req_3 high -> GAP next cycle, then gnt=1000, sel=11.
REQ-032 rst pulsed during gnt_2 with all req high -> outputs reset asynchronously; after release, first grant is gnt_0.

Source files
------------

// File: rtl/selector_arb_pkg.sv
// Shared definitions for the 4:1 selector arbiter: state encodings, counter width
// and a one-hot helper.
package selector_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int CNT_W = 8;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/selector_arbiter_rr_pick4.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ptr+3, ptr (mod 4),
// first asserted request wins.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] winner
);

    logic [1:0] idx;

    always_comb begin
        valid  = 1'b0;
        winner = ptr;
        idx    = ptr;
        for (int i = 1; i < 5; i++) begin
            idx = ptr + 2'(i);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/selector_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 selector path with hold-time preemption
// and a one-cycle break-before-make gap between owners.
//
//   state | meaning
//   IDLE  | no owner, path disabled
//   GRANT | ptr owns the path, en low, hold counter running
//   GAP   | one-cycle break between owners, path disabled, sel held
import selector_arb_pkg::*;

module selector_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req_0,
    input  logic req_1,
    input  logic req_2,
    input  logic req_3,
    output logic sel_1,
    output logic sel_0,
    output logic en,
    output logic gnt_0,
    output logic gnt_1,
    output logic gnt_2,
    output logic gnt_3,
    output logic busy
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    arb_state_t       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;

    logic [3:0] req_v;
    logic       pick_valid;
    logic [1:0] pick_winner;
    logic       others_req;

    assign req_v      = {req_3, req_2, req_1, req_0};
    assign others_req = |(req_v & ~onehot4(ptr_q));

    rr_pick4 u_pick (
        .req    (req_v),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            en_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE, GAP: begin
                cnt_d = '0;
                if (pick_valid) begin
                    state_d = GRANT;
                    ptr_d   = pick_winner;
                    sel_d   = pick_winner;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!req_v[ptr_q]) begin
                    state_d = GAP;
                end else if (cnt_q < HOLD_LIM) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (others_req) begin
                    state_d = GAP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they track it with no extra cycle.
        en_d   = (state_d != GRANT);
        gnt_d  = (state_d == GRANT) ? onehot4(ptr_d) : 4'b0000;
        busy_d = (state_d != IDLE);
    end

    assign sel_1 = sel_q[1];
    assign sel_0 = sel_q[0];
    assign en    = en_q;
    assign gnt_0 = gnt_q[0];
    assign gnt_1 = gnt_q[1];
    assign gnt_2 = gnt_q[2];
    assign gnt_3 = gnt_q[3];
    assign busy  = busy_q;

endmodule

// File: tb/tb_selector_arbiter.sv
// Scoreboard bench for selector_arbiter (HOLD_MAX=4): a behavioural model pushes the
// expected {gnt,sel,en,busy} when each req vector is driven; the value is popped after the edge.
module tb_selector_arbiter;

    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_0 = 1'b0, req_1 = 1'b0, req_2 = 1'b0, req_3 = 1'b0;
    logic sel_1, sel_0, en, gnt_0, gnt_1, gnt_2, gnt_3, busy;

    selector_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk   (clk),
        .rst   (rst),
        .req_0 (req_0),
        .req_1 (req_1),
        .req_2 (req_2),
        .req_3 (req_3),
        .sel_1 (sel_1),
        .sel_0 (sel_0),
        .en    (en),
        .gnt_0 (gnt_0),
        .gnt_1 (gnt_1),
        .gnt_2 (gnt_2),
        .gnt_3 (gnt_3),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    string tag = "init";
    logic [7:0] exp_q[$];

    // Model state: phase 0 = idle, 1 = owner holds path, 2 = gap cycle.
    int m_phase, m_owner, m_last, m_hold;
    logic [1:0] m_sel;

    task automatic chk(input string t, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got gnt/sel/en/busy=%b want=%b", t, got, want);
        end
    endtask

    function automatic logic [7:0] observed();
        return {gnt_3, gnt_2, gnt_1, gnt_0, sel_1, sel_0, en, busy};
    endfunction

    function automatic logic [7:0] model_out();
        logic [3:0] g;
        g = (m_phase == 1) ? (4'b0001 << m_owner) : 4'b0000;
        return {g, m_sel, (m_phase != 1), (m_phase != 0)};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_last = 3; m_hold = 0; m_sel = 2'd0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        int w;
        if (m_phase == 1) begin
            if (!r[m_owner])
                m_phase = 2;
            else if (m_hold < HOLD)
                m_hold++;
            else if ((r & ~(4'b0001 << m_owner)) != 4'b0000)
                m_phase = 2;
        end else begin
            w = -1;
            for (int k = 1; k <= 4; k++)
                if (w < 0 && r[(m_last + k) % 4]) w = (m_last + k) % 4;
            if (w >= 0) begin
                m_phase = 1; m_owner = w; m_last = w; m_hold = 1; m_sel = 2'(w);
            end else begin
                m_phase = 0;
            end
        end
    endtask

    task automatic pop_chk(input string t);
        if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL %s scoreboard empty, got %b", t, observed());
        end else begin
            chk(t, observed(), exp_q.pop_front());
        end
    endtask

    task automatic drive(input logic [3:0] r);
        {req_3, req_2, req_1, req_0} = r;
    endtask

    // Entered and left at a falling edge.
    task automatic step(input logic [3:0] r);
        drive(r);
        model_edge(r);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        pop_chk(tag);
        @(negedge clk);
    endtask

    // Reset asserted mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset(input logic [3:0] r);
        drive(r);
        rst = 1'b1;
        model_reset();
        exp_q.push_back(model_out());
        #1;
        pop_chk({tag, "_async"});
        repeat (2) begin
            exp_q.push_back(model_out());
            @(posedge clk);
            #1;
            pop_chk({tag, "_hold"});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        model_reset();
        @(negedge clk);

        tag = "reset_all_req";
        do_reset(4'b1111);

        tag = "first_grant_rr0";
        step(4'b1111);
        step(4'b0000);
        step(4'b0000);
        step(4'b0000);

        tag = "solo_req2";
        repeat (21) step(4'b0100);
        step(4'b0000);
        step(4'b0000);

        tag = "pair_req01";
        repeat (22) step(4'b0011);
        step(4'b0000);
        step(4'b0000);

        tag = "all_req";
        do_reset(4'b0000);
        repeat (26) step(4'b1111);

        tag = "owner_drop";
        do_reset(4'b0000);
        step(4'b1010);
        step(4'b1010);
        step(4'b1000);
        step(4'b1000);
        step(4'b1000);
        step(4'b0000);
        step(4'b0000);

        tag = "reach_gnt2";
        do_reset(4'b0000);
        guard = 0;
        while (!(m_phase == 1 && m_owner == 2) && guard < 40) begin
            step(4'b1111);
            guard++;
        end
        if (guard >= 40) begin
            n_vec++; n_err++;
            $display("FAIL reach_gnt2 owner=%0d phase=%0d want owner 2 in grant", m_owner, m_phase);
        end
        step(4'b1111);

        tag = "rst_mid_grant";
        do_reset(4'b1111);
        tag = "post_rst_gnt0";
        step(4'b1111);
        step(4'b1111);

        tag = "random";
        repeat (60) step(4'($urandom_range(0, 15)));

        tag = "drain";
        step(4'b0000);
        step(4'b0000);

        if (exp_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL drain leftover=%0d want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
